// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types and constants for the fetch/data memory port
//                arbiter: FSM state encoding, grant identifiers and the
//                latency-counter width helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Grant identifiers; also the encoding of the last-grant register.
    localparam logic c_FETCH = 1'b0;
    localparam logic c_DATA  = 1'b1;

    // Width of the latency down-counter. It is loaded with LATENCY-1, so
    // $clog2(LATENCY+1) bits always suffice; the guard keeps it >= 1 bit.
    function automatic int cnt_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundle of the fetch request port, the load/store request
//                port and the single-port memory command/response bus.
//  Modports    : slave  - arbiter view (takes requests, drives memory)
//                master - core + memory model view
//  Signals     : if_req/if_addr/if_rdata/if_ready      fetch port
//                d_req/d_we/d_addr/d_wdata/d_rdata/d_ready  data port
//                mem_en/mem_we/mem_addr/mem_wdata/mem_rdata memory bus
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    // Instruction-fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    // Load/store port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    // Memory bus
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ready,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ready,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_rr_arbiter2
//  Description : Two-requester round-robin pick (fetch vs data). A single
//                request wins outright; on a tie the side that did not win
//                last time is chosen. The last-grant register only moves
//                when the caller actually takes the grant.
//  Ports       : clock         in  system clock
//                reset         in  asynchronous active-low reset
//                i_req_fetch   in  fetch request
//                i_req_data    in  data request
//                i_take        in  grant is consumed this cycle
//                o_grant_valid out at least one request present
//                o_grant_id    out winner (c_FETCH / c_DATA)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter_rr_arbiter2
    import mem_port_arbiter_pkg::*;
(
    input  wire  clock,
    input  wire  reset,
    input  wire  i_req_fetch,
    input  wire  i_req_data,
    input  wire  i_take,
    output logic o_grant_valid,
    output logic o_grant_id
);

    logic r_last_grant;

    always_comb begin
        o_grant_valid = i_req_fetch | i_req_data;
        o_grant_id    = c_FETCH;
        if (i_req_fetch && i_req_data) begin
            o_grant_id = ~r_last_grant;
        end else if (i_req_data) begin
            o_grant_id = c_DATA;
        end
    end

    // Starts at FETCH so that the first tie after reset goes to data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= c_FETCH;
        end else if (i_take && o_grant_valid) begin
            r_last_grant <= o_grant_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between instruction fetch and
//                load/store. Requests are serialised; each granted access
//                runs IDLE -> ISSUE (one-cycle mem_en) -> WAIT (fixed
//                latency) -> RESP (one-cycle ready to the winner).
//  Parameters  : DATA_W      data word width
//                ADDR_W      byte address width
//                MEM_LATENCY cycles from mem_en to valid mem_rdata (>= 1)
//  Ports       : clock  in   system clock, rising edge
//                reset  in   asynchronous active-low reset
//                bus    --   mem_port_arbiter_if.slave (fetch, data, memory)
//                busy   out  high whenever the sequencer is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  wire                clock,
    input  wire                reset,
    mem_port_arbiter_if.slave  bus,
    output logic               busy
);

    localparam int               CNT_W      = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_grant;
    logic              w_grant_valid;
    logic              w_grant_id;
    logic              w_take;
    logic              w_cnt_done;

    logic              r_mem_en;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_if_ready;
    logic              r_d_ready;

    mem_port_arbiter_rr_arbiter2 u_rr_arbiter2 (
        .clock         (clock),
        .reset         (reset),
        .i_req_fetch   (bus.if_req),
        .i_req_data    (bus.d_req),
        .i_take        (w_take),
        .o_grant_valid (w_grant_valid),
        .o_grant_id    (w_grant_id)
    );

    // Last WAIT cycle: memory data is valid on mem_rdata right now.
    assign w_cnt_done = (r_state == ST_WAIT) && (r_cnt == '0);

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and grant acceptance
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched command, latency counter, responses
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_grant     <= c_FETCH;
            r_cnt       <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
        end else begin
            // mem_en is high exactly for the ISSUE cycle.
            r_mem_en <= w_take;

            // Command fields are captured at grant time and left untouched
            // until the next grant, so later request changes are ignored.
            if (w_take) begin
                r_grant <= w_grant_id;
                if (w_grant_id == c_DATA) begin
                    r_mem_we    <= bus.d_we;
                    r_mem_addr  <= bus.d_addr;
                    r_mem_wdata <= bus.d_wdata;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= bus.if_addr;
                    r_mem_wdata <= '0;
                end
            end

            if (r_state == ST_ISSUE) begin
                r_cnt <= c_CNT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            r_if_ready <= w_cnt_done && (r_grant == c_FETCH);
            r_d_ready  <= w_cnt_done && (r_grant == c_DATA);

            // Each requester keeps its own read data so it holds between
            // its own accesses; stores leave it unchanged.
            if (w_cnt_done && !r_mem_we) begin
                if (r_grant == c_DATA) begin
                    r_d_rdata <= bus.mem_rdata;
                end else begin
                    r_if_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.if_ready  = r_if_ready;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.d_ready   = r_d_ready;
    assign busy          = (r_state != ST_IDLE);

endmodule
`default_nettype wire
